goto_rep_stim: RTL and testbench

Synthesizable stimulus generator that drives the transmit side of the goto-repetition handshake. The assertion checker on the other end enforces `a |-> b[->N] ##1 c`. On each `start` pulse the block emits a one-cycle `a`, then exactly N non-consecutive (or consecutive) `b` pulses separated by a programmable idle gap, then `c` exactly one cycle after the Nth `b`. It sits in the assertion bench as the driver feeding the checker. It also provides an error-injection mode that produces a deliberately failing sequence.

---
 rtl/goto_rep_pkg.sv | 16 +
 rtl/goto_rep_stim.sv | 112 +++++++++++
 tb/tb_goto_rep_stim.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/goto_rep_pkg.sv
// Shared types and default constants for the goto-repetition stimulus generator
// and the checker bench that consumes its a/b/c handshake.
package goto_rep_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FIRE_A,
    GAP,
    HIT,
    FIRE_C
  } goto_state_e;

  localparam int GOTO_N_HITS = 3;
  localparam int GOTO_GAP_W  = 4;

endpackage : goto_rep_pkg

// File: rtl/goto_rep_stim.sv
// Stimulus generator for `a |-> b[->N] ##1 c`: one a, N b pulses spaced by a
// latched idle gap, then c (optionally suppressed for error injection).
module goto_rep_stim
  import goto_rep_pkg::*;
#(
  parameter int N_HITS = GOTO_N_HITS,
  parameter int GAP_W  = GOTO_GAP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [GAP_W-1:0] gap,
  input  logic             err_inj,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             busy,
  output logic             done
);

  localparam int HIT_W = $clog2(N_HITS + 1);

  goto_state_e      state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] cnt_q, cnt_d;
  logic [HIT_W-1:0] hit_q, hit_d;
  logic             err_q, err_d;
  logic             a_q, b_q, c_q, busy_q, done_q;

  // NOTE: every variable gets its hold value before the case so that no path
  // through the decode leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    hit_d   = hit_q;
    unique case (state_q)
      IDLE: begin
        hit_d = '0;
        if (start) begin
          state_d = FIRE_A;
          gap_d   = gap;
          err_d   = err_inj;
        end
      end
      FIRE_A: begin
        cnt_d   = gap_q;
        state_d = (gap_q != '0) ? GAP : HIT;
      end
      GAP: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == GAP_W'(1)) state_d = HIT;
      end
      HIT: begin
        hit_d = hit_q + 1'b1;
        if (hit_q == HIT_W'(N_HITS - 1)) begin
          state_d = FIRE_C;
        end else if (gap_q != '0) begin
          state_d = GAP;
          cnt_d   = gap_q;
        end else begin
          state_d = HIT;
        end
      end
      FIRE_C:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gap_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      hit_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
    end
  end

  // Outputs are the current state decoded one cycle late, so they leave flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= 1'b0;
      b_q    <= 1'b0;
      c_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_q    <= (state_q == FIRE_A);
      b_q    <= (state_q == HIT);
      c_q    <= (state_q == FIRE_C) && !err_q;
      busy_q <= (state_q != IDLE);
      done_q <= (state_q == FIRE_C);
    end
  end

  assign a    = a_q;
  assign b    = b_q;
  assign c    = c_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule : goto_rep_stim

// File: tb/tb_goto_rep_stim.sv
// Scoreboard bench: stimulus pushes timestamped expected a/b/c/done events,
// monitors pop and compare whenever the generators emit an output pulse.
module tb_goto_rep_stim;
  import goto_rep_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, err_inj;
  logic [3:0] gap;
  logic       a, b, c, busy, done;

  logic       start1;
  logic [3:0] gap1;
  logic       err1;
  logic       a1, b1, c1, busy1, done1;

  goto_rep_stim #(.N_HITS(3), .GAP_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .gap(gap), .err_inj(err_inj),
    .a(a), .b(b), .c(c), .busy(busy), .done(done)
  );

  goto_rep_stim #(.N_HITS(1), .GAP_W(4)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .gap(gap1), .err_inj(err1),
    .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] v;   // {a, b, c, done}
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];
  int  checks = 0;
  int  errors = 0;
  int  b_lo = 0;
  int  b_hi = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    check("busy0", {31'd0, busy}, (cyc >= b_lo && cyc <= b_hi) ? 1 : 0);
    if ({a, b, c, done} != 4'b0000) begin
      if (q0.size() == 0) begin
        check("unexpected_event0", {28'd0, a, b, c, done}, 0);
      end else begin
        e = q0.pop_front();
        check("event_cycle0", cyc, e.cyc);
        check("event_value0", {28'd0, a, b, c, done}, {28'd0, e.v});
      end
    end
  end

  always @(negedge clk) begin
    ev_t e;
    if ({a1, b1, c1, done1} != 4'b0000) begin
      if (q1.size() == 0) begin
        check("unexpected_event1", {28'd0, a1, b1, c1, done1}, 0);
      end else begin
        e = q1.pop_front();
        check("event_cycle1", cyc, e.cyc);
        check("event_value1", {28'd0, a1, b1, c1, done1}, {28'd0, e.v});
      end
    end
  end

  // Drive point: shortly after a rising edge, well away from the sampling edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_seq(input int t0, input int g, input bit err);
    ev_t e;
    e = '{t0 + 1, 4'b1000};
    q0.push_back(e);
    for (int k = 1; k <= 3; k++) begin
      e = '{t0 + 1 + k * (g + 1), 4'b0100};
      q0.push_back(e);
    end
    e = '{t0 + 2 + 3 * (g + 1), err ? 4'b0001 : 4'b1010 & 4'b0000 | 4'b0011};
    q0.push_back(e);
    b_lo = t0 + 1;
    b_hi = t0 + 2 + 3 * (g + 1);
  endtask

  task automatic drain0;
    for (int i = 0; i < 200 && q0.size() != 0; i++) step(1);
    check("drain0_timeout", q0.size(), 0);
    step(3);
  endtask

  task automatic run_seq(input int g, input bit err);
    int t0;
    start   = 1'b1;
    gap     = 4'(g);
    err_inj = err;
    t0      = cyc + 1;
    push_seq(t0, g, err);
    step(1);
    start   = 1'b0;
    gap     = ~4'(g);
    err_inj = ~err;
    drain0();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t0;
    rst = 1'b1; start = 1'b0; gap = '0; err_inj = 1'b0;
    start1 = 1'b0; gap1 = '0; err1 = 1'b0;
    step(3);
    #1;
    check("reset_a", {31'd0, a}, 0);
    check("reset_b", {31'd0, b}, 0);
    check("reset_c", {31'd0, c}, 0);
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_done", {31'd0, done}, 0);
    rst = 1'b0;
    step(2);

    // Consecutive hits, spaced hits, error injection, maximum gap.
    run_seq(0, 1'b0);
    run_seq(2, 1'b0);
    run_seq(1, 1'b1);
    run_seq(15, 1'b0);

    // Late gap change and a second start while busy leave the sequence intact.
    start = 1'b1; gap = 4'd1; err_inj = 1'b0;
    t0 = cyc + 1;
    push_seq(t0, 1, 1'b0);
    step(1);
    start = 1'b0;
    step(2);
    gap = 4'd5;
    step(2);
    start = 1'b1;
    step(1);
    start = 1'b0;
    drain0();

    // Reset in the middle of a gap=2 sequence abandons it.
    start = 1'b1; gap = 4'd2;
    t0 = cyc + 1;
    push_seq(t0, 2, 1'b0);
    step(1);
    start = 1'b0;
    step(5);
    rst  = 1'b1;
    b_hi = -1;
    q0.delete();
    #1;
    check("midrst_a", {31'd0, a}, 0);
    check("midrst_b", {31'd0, b}, 0);
    check("midrst_c", {31'd0, c}, 0);
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_done", {31'd0, done}, 0);
    step(2);
    rst = 1'b0;
    step(1);
    run_seq(2, 1'b0);

    // Start present only while reset is high at the edge is ignored.
    rst = 1'b1; start = 1'b1;
    step(1);
    rst = 1'b0; start = 1'b0;
    step(6);
    check("coincident_busy", {31'd0, busy}, 0);

    // N_HITS=1 with start held: a,b,c then a again two cycles after c.
    start1 = 1'b1;
    t0 = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      q1.push_back('{t0 + 4 * k + 1, 4'b1000});
      q1.push_back('{t0 + 4 * k + 2, 4'b0100});
      q1.push_back('{t0 + 4 * k + 3, 4'b0011});
    end
    step(9);
    start1 = 1'b0;
    for (int i = 0; i < 100 && q1.size() != 0; i++) step(1);
    check("drain1_timeout", q1.size(), 0);
    step(6);
    check("final_q0_empty", q0.size(), 0);
    check("final_busy1", {31'd0, busy1}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_goto_rep_stim
